// File: rtl/and_or.sv
// and_or: three-input AND-OR gate f = (a & b) | c with a clocked sampling
// wrapper that keeps a registered result, a sticky coverage bitmap of the
// sampled {a,b,c} combinations and a saturating count of true results.
module and_or #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             en,
  output logic             f,
  output logic             f_q,
  output logic [7:0]       seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0] idx;

  // Combinational gate result and coverage summary; neither depends on clk or rst.
  always_comb begin
    f        = (a & b) | c;
    idx      = {a, b, c};
    all_seen = &seen;
  end

  // Sample on enabled edges; reset wins over enable, counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q      <= 1'b0;
      seen     <= 8'h00;
      ones_cnt <= '0;
    end else if (en) begin
      f_q       <= f;
      seen[idx] <= 1'b1;
      if (f && (ones_cnt != CNT_MAX)) begin
        ones_cnt <= ones_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_and_or.sv
// tb_and_or: directed bench for and_or. A behavioural model (truth table
// lookup, per-combination flags, integer counters with a ceiling) is checked
// against two DUT instances (default width and a 3-bit counter) every cycle,
// alongside hand-computed literal expectations for each scenario.
module tb_and_or;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, en = 1'b0;

  logic        f_w, f_q_w, all_seen_w;
  logic [7:0]  seen_w;
  logic [15:0] cnt_w;
  logic        f_n, f_q_n, all_seen_n;
  logic [7:0]  seen_n;
  logic [2:0]  cnt_n;

  int checks = 0;
  int errors = 0;

  and_or #(.CNT_W(16)) dut_wide (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
    .f(f_w), .f_q(f_q_w), .seen(seen_w), .all_seen(all_seen_w), .ones_cnt(cnt_w)
  );

  and_or #(.CNT_W(3)) dut_narrow (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
    .f(f_n), .f_q(f_q_n), .seen(seen_n), .all_seen(all_seen_n), .ones_cnt(cnt_n)
  );

  always #5 clk = ~clk;

  // Truth table straight from the gate definition, index {a,b,c}.
  int tt [8] = '{0, 1, 0, 1, 0, 1, 1, 1};

  // Model state.
  bit m_valid = 0;
  bit m_seen [8];
  int m_fq = 0;
  int m_cnt_w = 0;
  int m_cnt_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_seen();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) if (m_seen[i]) v = v | (8'h01 << i);
    return v;
  endfunction

  function automatic int model_seen_count();
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (m_seen[i]) n++;
    return n;
  endfunction

  // Model update on each rising edge from the inputs held stable across it.
  always @(posedge clk) begin
    int k;
    k = int'({a, b, c});
    if (rst) begin
      m_valid = 1;
      for (int i = 0; i < 8; i++) m_seen[i] = 0;
      m_fq = 0;
      m_cnt_w = 0;
      m_cnt_n = 0;
    end else if (en) begin
      m_seen[k] = 1;
      m_fq = tt[k];
      if (tt[k] == 1) begin
        m_cnt_w = (m_cnt_w + 1 > 65535) ? 65535 : m_cnt_w + 1;
        m_cnt_n = (m_cnt_n + 1 > 7) ? 7 : m_cnt_n + 1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    chk("f_wide", 32'(f_w), 32'(tt[int'({a, b, c})]));
    chk("f_narrow", 32'(f_n), 32'(tt[int'({a, b, c})]));
    if (m_valid) begin
      chk("f_q_wide", 32'(f_q_w), 32'(m_fq));
      chk("f_q_narrow", 32'(f_q_n), 32'(m_fq));
      chk("seen_wide", 32'(seen_w), 32'(model_seen()));
      chk("seen_narrow", 32'(seen_n), 32'(model_seen()));
      chk("all_seen_wide", 32'(all_seen_w), 32'(model_seen_count() == 8));
      chk("all_seen_narrow", 32'(all_seen_n), 32'(model_seen_count() == 8));
      chk("cnt_wide", 32'(cnt_w), 32'(m_cnt_w));
      chk("cnt_narrow", 32'(cnt_n), 32'(m_cnt_n));
    end
  end

  task automatic drive(input logic [2:0] abc, input logic e);
    @(negedge clk);
    {a, b, c} = abc;
    en = e;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] part_seq [4] = '{3'b011, 3'b011, 3'b110, 3'b000};
  int f_exp_list [8] = '{0, 1, 0, 1, 0, 1, 1, 1};

  initial begin
    // Reset and pin reset values.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_f_q", 32'(f_q_w), 32'h0);
    chk("reset_seen", 32'(seen_w), 32'h00);
    chk("reset_cnt", 32'(cnt_w), 32'h0);
    chk("reset_all_seen", 32'(all_seen_w), 32'h0);

    // 1: combinational sweep with en low.
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      chk("sweep_f", 32'(f_w), 32'(f_exp_list[i]));
      #49;
    end
    chk("sweep_seen", 32'(seen_w), 32'h00);
    chk("sweep_cnt", 32'(cnt_w), 32'h0);
    chk("sweep_f_q", 32'(f_q_w), 32'h0);

    // 2: full coverage sweep.
    do_reset();
    for (int i = 0; i < 8; i++) drive(3'(i), 1'b1);
    drive(3'b000, 1'b0);
    chk("cov_seen", 32'(seen_w), 32'hFF);
    chk("cov_all_seen", 32'(all_seen_w), 32'h1);
    chk("cov_cnt", 32'(cnt_w), 32'd5);
    chk("cov_f_q", 32'(f_q_w), 32'h1);

    // 3: partial coverage with a repeat.
    do_reset();
    for (int i = 0; i < 4; i++) drive(part_seq[i], 1'b1);
    drive(3'b000, 1'b0);
    chk("part_seen", 32'(seen_w), 32'h49);
    chk("part_all_seen", 32'(all_seen_w), 32'h0);
    chk("part_cnt", 32'(cnt_w), 32'd3);
    chk("part_f_q", 32'(f_q_w), 32'h0);

    // 4: enable gating with f high.
    drive(3'b001, 1'b0);
    repeat (10) @(negedge clk);
    chk("gate_f", 32'(f_w), 32'h1);
    chk("gate_seen", 32'(seen_w), 32'h49);
    chk("gate_cnt", 32'(cnt_w), 32'd3);
    chk("gate_f_q", 32'(f_q_w), 32'h0);

    // 5: saturation on the 3-bit instance.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(3'b111, 1'b1);
      @(posedge clk);
      #1;
      if (i == 6) chk("sat_narrow_6", 32'(cnt_n), 32'd6);
      if (i == 7) chk("sat_narrow_7", 32'(cnt_n), 32'd7);
    end
    drive(3'b111, 1'b0);
    chk("sat_narrow_10", 32'(cnt_n), 32'd7);
    chk("sat_wide_10", 32'(cnt_w), 32'd10);

    // 6: reset priority over enable with nonzero state.
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    {a, b, c} = 3'b111;
    @(posedge clk);
    #1;
    chk("rstpri_f_q", 32'(f_q_w), 32'h0);
    chk("rstpri_seen", 32'(seen_w), 32'h00);
    chk("rstpri_cnt", 32'(cnt_w), 32'h0);
    chk("rstpri_all_seen", 32'(all_seen_w), 32'h0);
    chk("rstpri_f", 32'(f_w), 32'h1);

    // First post-reset sample counts normally.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cnt", 32'(cnt_w), 32'd1);
    chk("post_rst_seen", 32'(seen_w), 32'h80);

    drive(3'b000, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
